// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: a DIGIT-bit ripple slice reused over WIDTH/DIGIT
// cycles, with valid/ready handshakes on input and output.
`timescale 1ns/1ps

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT:0]   dsum;
  logic             cm;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_step = (state_q == RUN) && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One digit of ripple add; the carry into the digit MSB is recovered from its sum bit.
  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign cm   = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  // Sum digits enter from the top so the first (least significant) digit ends at the bottom.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_next = dsum[DIGIT-1:0];
    end else begin : g_multi
      assign res_next = {dsum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b here and seed the carry with sub.
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      cnt_q   <= '0;
      res_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      res_q   <= res_next;
      carry_q <= dsum[DIGIT];
      cnt_q   <= cnt_q + CW'(1);
      if (last_step) begin
        cout_q <= dsum[DIGIT];
        ovf_q  <= cm ^ dsum[DIGIT];
      end
    end
  end

  assign s    = res_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: four instances (8/1, 8/2, 8/8, 16/4)
// checked against an arithmetic reference model with randomized traffic.
`timescale 1ns/1ps

module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid_d, in_ready_d, sub_d, cout_d, ovf_d, out_valid_d, out_ready_d;
  logic [15:0] a_d [4];
  logic [15:0] b_d [4];
  logic [15:0] s_d [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int W = (k == 3) ? 16 : 8;
    localparam int D = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 4;
    logic [W-1:0] s_loc;
    serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_d[k]),
      .in_ready  (in_ready_d[k]),
      .a         (a_d[k][W-1:0]),
      .b         (b_d[k][W-1:0]),
      .sub       (sub_d[k]),
      .s         (s_loc),
      .cout      (cout_d[k]),
      .ovf       (ovf_d[k]),
      .out_valid (out_valid_d[k]),
      .out_ready (out_ready_d[k])
    );
    assign s_d[k] = 16'(s_loc);
  end

  function automatic int wid(input int k);
    return (k == 3) ? 16 : 8;
  endfunction

  function automatic int nsteps(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : (k == 2) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                    input logic sv, output logic [15:0] so,
                                    output logic co, output logic oo);
    longint full, half, ua, ub, sa, sb, r, sr;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    ua = longint'(av) & (full - 1);
    ub = longint'(bv) & (full - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (sv) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      co = (r >= full);
      sr = sa + sb;
    end
    so = 16'(r & (full - 1));
    oo = (sr >= half) || (sr < -half);
  endfunction

  // One full transaction on instance k; bp = cycles of out_ready backpressure in DONE.
  task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input int bp,
                       output logic [15:0] so, output logic co, output logic oo);
    int guard = 0;
    int lat = 0;
    while (in_ready_d[k] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(in_ready_d[k]), 32'd1);
    a_d[k] = av; b_d[k] = bv; sub_d[k] = sv;
    in_valid_d[k]  = 1'b1;
    out_ready_d[k] = (bp == 0);
    @(negedge clk);
    in_valid_d[k] = 1'b0;
    check("in_ready_drop", 32'(in_ready_d[k]), 32'd0);
    while (out_valid_d[k] !== 1'b1 && lat < 50) begin
      a_d[k] = 16'($urandom); b_d[k] = 16'($urandom);
      sub_d[k] = 1'($urandom); in_valid_d[k] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid_d[k] = 1'b0;
    check("latency", 32'(lat), 32'(nsteps(k)));
    so = s_d[k]; co = cout_d[k]; oo = ovf_d[k];
    for (int i = 0; i < bp; i++) begin
      a_d[k] = 16'($urandom); b_d[k] = 16'($urandom);
      sub_d[k] = 1'($urandom); in_valid_d[k] = 1'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid_d[k]), 32'd1);
      check("hold_ready", 32'(in_ready_d[k]), 32'd0);
      check("hold_s", 32'(s_d[k]), 32'(so));
      check("hold_cout", 32'(cout_d[k]), 32'(co));
      check("hold_ovf", 32'(ovf_d[k]), 32'(oo));
    end
    in_valid_d[k]  = 1'b0;
    out_ready_d[k] = 1'b1;
    @(negedge clk);
    check("ret_idle", 32'(in_ready_d[k]), 32'd1);
    check("ret_novalid", 32'(out_valid_d[k]), 32'd0);
    @(negedge clk);
    check("no_restart", 32'(in_ready_d[k]), 32'd1);
  endtask

  task automatic expect_res(input string tag, input logic [15:0] so, input logic co, input logic oo,
                            input logic [15:0] es, input logic ec, input logic eo);
    check({tag, "_s"}, 32'(so), 32'(es));
    check({tag, "_cout"}, 32'(co), 32'(ec));
    check({tag, "_ovf"}, 32'(oo), 32'(eo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] so, es, av, bv;
    logic        co, oo, ec, eo, sv;
    int          acc_cyc [$];
    int          cyc;

    rst = 1'b1;
    in_valid_d = '0; sub_d = '0; out_ready_d = '1;
    for (int k = 0; k < 4; k++) begin
      a_d[k] = '0; b_d[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready", 32'(in_ready_d[k]), 32'd1);
      check("rst_out_valid", 32'(out_valid_d[k]), 32'd0);
      check("rst_s", 32'(s_d[k]), 32'd0);
      check("rst_cout", 32'(cout_d[k]), 32'd0);
      check("rst_ovf", 32'(ovf_d[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases on the 8-bit, 1-bit-digit instance.
    do_op(0, 16'h7F, 16'h01, 1'b0, 0, so, co, oo);
    expect_res("add_7f_01", so, co, oo, 16'h80, 1'b0, 1'b1);
    do_op(0, 16'hFF, 16'h01, 1'b0, 0, so, co, oo);
    expect_res("add_ff_01", so, co, oo, 16'h00, 1'b1, 1'b0);
    do_op(0, 16'h05, 16'h07, 1'b1, 0, so, co, oo);
    expect_res("sub_05_07", so, co, oo, 16'hFE, 1'b0, 1'b0);
    do_op(0, 16'h80, 16'h01, 1'b1, 0, so, co, oo);
    expect_res("sub_80_01", so, co, oo, 16'h7F, 1'b1, 1'b1);

    // Backpressure: five cycles stalled in DONE with input churn.
    do_op(0, 16'h3C, 16'h0F, 1'b1, 5, so, co, oo);
    expect_res("bp_sub_3c_0f", so, co, oo, 16'h2D, 1'b1, 1'b0);

    // Reset in the third RUN cycle.
    a_d[0] = 16'h12; b_d[0] = 16'h34; sub_d[0] = 1'b0; in_valid_d[0] = 1'b1;
    @(negedge clk);
    in_valid_d[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready_d[0]), 32'd1);
    check("midrst_out_valid", 32'(out_valid_d[0]), 32'd0);
    check("midrst_s", 32'(s_d[0]), 32'd0);
    rst = 1'b0;
    do_op(0, 16'h10, 16'h20, 1'b0, 0, so, co, oo);
    expect_res("post_rst_add", so, co, oo, 16'h30, 1'b0, 1'b0);

    // 16-bit, 4-bit-digit instance.
    do_op(3, 16'h8000, 16'h8000, 1'b0, 0, so, co, oo);
    expect_res("w16_add_8000", so, co, oo, 16'h0000, 1'b1, 1'b1);

    // Back-to-back accepts: spacing must be N+2 = 6 cycles.
    a_d[3] = 16'h1234; b_d[3] = 16'h0101; sub_d[3] = 1'b0;
    in_valid_d[3] = 1'b1; out_ready_d[3] = 1'b1;
    cyc = 0;
    while (acc_cyc.size() < 3 && cyc < 100) begin
      if (in_ready_d[3] === 1'b1) acc_cyc.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    in_valid_d[3] = 1'b0;
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    end
    repeat (12) @(negedge clk);

    // Randomized traffic on the 8-bit instances against the reference model.
    for (int n = 0; n < 1000; n++) begin
      int k = n % 3;
      int bp;
      av = 16'($urandom_range(0, 255));
      bv = 16'($urandom_range(0, 255));
      sv = 1'($urandom_range(0, 1));
      bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ref_model(wid(k), av, bv, sv, es, ec, eo);
      do_op(k, av, bv, sv, bp, so, co, oo);
      expect_res("rand", so, co, oo, es, ec, eo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
